// File: rtl/pc_gen_v2.sv
// pc_gen_v2: fetch program-counter generator for the riscv32i front end.
//
// Ports:
//   clk_i, reset_ni          clock, async active-low reset
//   enable_design_i          global run enable
//   initial_pc_i             boot PC, loaded in LOAD
//   fetch_ready_i            IF accepts pc_o this cycle
//   pc_o / pc_valid_o        fetch PC and its valid flag (registered)
//   nextpc_o                 PC loaded on the next advance (combinational)
//   jump_i, branch_i,
//   target_pc_i              EX-resolved jump/branch redirect
//   irq_prep_i, irq_vector_i interrupt-entry redirect
//   mret_i, mepc_i           trap-return redirect
//   flush_o, misaligned_o    one-cycle pulses after a redirect is applied
//   redirect_pending_o       a redirect is held while the design is not running
//   bru_*                    BTB update port
//   pred_taken_o             nextpc_o comes from a BTB hit (combinational)
//
// Build option: define PC_BTB_EN to include the direct-mapped BTB.
module pc_gen_v2 #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned INST_BYTES = 4,
   parameter int unsigned BTB_DEPTH  = 8
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            enable_design_i,
   input  logic [XLEN-1:0] initial_pc_i,
   input  logic            fetch_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic [XLEN-1:0] nextpc_o,
   input  logic            jump_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] target_pc_i,
   input  logic            irq_prep_i,
   input  logic [XLEN-1:0] irq_vector_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            flush_o,
   output logic            misaligned_o,
   output logic            redirect_pending_o,
   input  logic            bru_update_i,
   input  logic [XLEN-1:0] bru_pc_i,
   input  logic            bru_taken_i,
   input  logic [XLEN-1:0] bru_target_i,
   output logic            pred_taken_o
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = (INST_BYTES == 2) ? ~XLEN'(1) : ~XLEN'(3);

   state_t            r_state, w_state_nxt;
   logic [XLEN-1:0]   r_pc, w_pc_nxt;
   logic              r_pc_valid, r_flush, r_mis;
   logic              r_pend_vld, w_pend_vld_nxt;
   logic [XLEN-1:0]   r_pend_tgt, w_pend_tgt_nxt;
   logic              w_apply, w_mis;
   logic [XLEN-1:0]   w_apply_raw;
   logic              w_redir_vld;
   logic [XLEN-1:0]   w_redir_tgt;
   logic [XLEN-1:0]   w_seq_pc, w_nextpc;
   logic              w_btb_hit;
   logic [XLEN-1:0]   w_btb_tgt;
   logic              w_pred;

   // Fixed redirect priority: mret > irq > jump/branch
   assign w_redir_vld = mret_i | irq_prep_i | jump_i | branch_i;
   assign w_redir_tgt = mret_i     ? mepc_i       :
                        irq_prep_i ? irq_vector_i : target_pc_i;

   assign w_seq_pc = r_pc + XLEN'(INST_BYTES);
   assign w_pred   = w_btb_hit && (r_state == S_RUN) && !w_redir_vld;
   assign w_nextpc = w_pred ? w_btb_tgt : w_seq_pc;

`ifdef PC_BTB_EN
   localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   logic [BTB_DEPTH-1:0] r_btb_vld;
   logic [TAG_W-1:0]     r_btb_tag [BTB_DEPTH];
   logic [XLEN-1:0]      r_btb_tgt [BTB_DEPTH];
   logic [IDX_W-1:0]     w_lk_idx, w_up_idx;
   logic [TAG_W-1:0]     w_lk_tag, w_up_tag;
   logic                 w_unused_bru;

   assign w_lk_idx     = r_pc[IDX_W+1:2];
   assign w_lk_tag     = r_pc[XLEN-1:IDX_W+2];
   assign w_up_idx     = bru_pc_i[IDX_W+1:2];
   assign w_up_tag     = bru_pc_i[XLEN-1:IDX_W+2];
   assign w_unused_bru = ^bru_pc_i[1:0];

   // Lookup reads the pre-update entry; no write-through bypass
   assign w_btb_hit = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
   assign w_btb_tgt = r_btb_tgt[w_lk_idx];

   // Valid bits: taken sets, not-taken clears only on a tag match
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_btb_vld <= '0;
      end else if (bru_update_i) begin
         if (bru_taken_i)
            r_btb_vld[w_up_idx] <= 1'b1;
         else if (r_btb_tag[w_up_idx] == w_up_tag)
            r_btb_vld[w_up_idx] <= 1'b0;
      end
   end

   // Tag/target payload needs no reset; valid bits gate its use
   always_ff @(posedge clk_i) begin
      if (bru_update_i && bru_taken_i) begin
         r_btb_tag[w_up_idx] <= w_up_tag;
         r_btb_tgt[w_up_idx] <= bru_target_i;
      end
   end
`else
   logic w_unused_bru;

   assign w_btb_hit    = 1'b0;
   assign w_btb_tgt    = '0;
   assign w_unused_bru = ^{bru_update_i, bru_pc_i, bru_taken_i, bru_target_i, 1'(BTB_DEPTH)};
`endif

   // Next-state, next-PC and pending-redirect logic
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_pend_vld_nxt = r_pend_vld;
      w_pend_tgt_nxt = r_pend_tgt;
      w_apply        = 1'b0;
      w_apply_raw    = w_redir_tgt;
      case (r_state)
         S_IDLE: begin
            if (enable_design_i) w_state_nxt = S_LOAD;
            if (w_redir_vld) begin
               w_pend_vld_nxt = 1'b1;
               w_pend_tgt_nxt = w_redir_tgt;
            end
         end
         S_LOAD: begin
            // Redirects arriving here are intentionally dropped
            w_pc_nxt    = initial_pc_i & ALIGN_MASK;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!enable_design_i) w_state_nxt = S_HALT;
            if (w_redir_vld) begin
               w_apply        = 1'b1;
               w_pend_vld_nxt = 1'b0;
            end else if (fetch_ready_i) begin
               w_pc_nxt = w_nextpc;
            end
         end
         S_HALT: begin
            if (enable_design_i) begin
               w_state_nxt = S_RUN;
               // A fresh redirect on the restart edge beats the held one
               if (w_redir_vld) begin
                  w_apply        = 1'b1;
                  w_pend_vld_nxt = 1'b0;
               end else if (r_pend_vld) begin
                  w_apply        = 1'b1;
                  w_apply_raw    = r_pend_tgt;
                  w_pend_vld_nxt = 1'b0;
               end
            end else if (w_redir_vld) begin
               w_pend_vld_nxt = 1'b1;
               w_pend_tgt_nxt = w_redir_tgt;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_apply) w_pc_nxt = w_apply_raw & ALIGN_MASK;
      w_mis = w_apply && ((w_apply_raw & ~ALIGN_MASK) != '0);
   end

   // State, PC and registered status outputs
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_pc_valid <= 1'b0;
         r_flush    <= 1'b0;
         r_mis      <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_pc_valid <= (w_state_nxt == S_RUN);
         r_flush    <= w_apply;
         r_mis      <= w_mis;
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
      end
   end

   assign pc_o               = r_pc;
   assign pc_valid_o         = r_pc_valid;
   assign nextpc_o           = w_nextpc;
   assign flush_o            = r_flush;
   assign misaligned_o       = r_mis;
   assign redirect_pending_o = r_pend_vld;
   assign pred_taken_o       = w_pred;

endmodule

// File: tb/tb_pc_gen_v2.sv
// tb_pc_gen_v2: directed vector bench for pc_gen_v2 (INST_BYTES=4).
module tb_pc_gen_v2;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        enable_design_i;
   logic [31:0] initial_pc_i;
   logic        fetch_ready_i;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic [31:0] nextpc_o;
   logic        jump_i, branch_i;
   logic [31:0] target_pc_i;
   logic        irq_prep_i;
   logic [31:0] irq_vector_i;
   logic        mret_i;
   logic [31:0] mepc_i;
   logic        flush_o, misaligned_o, redirect_pending_o;
   logic        bru_update_i;
   logic [31:0] bru_pc_i;
   logic        bru_taken_i;
   logic [31:0] bru_target_i;
   logic        pred_taken_o;

   int n_checks = 0;
   int n_err    = 0;

   pc_gen_v2 dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .enable_design_i(enable_design_i),
      .initial_pc_i(initial_pc_i), .fetch_ready_i(fetch_ready_i),
      .pc_o(pc_o), .pc_valid_o(pc_valid_o), .nextpc_o(nextpc_o),
      .jump_i(jump_i), .branch_i(branch_i), .target_pc_i(target_pc_i),
      .irq_prep_i(irq_prep_i), .irq_vector_i(irq_vector_i),
      .mret_i(mret_i), .mepc_i(mepc_i),
      .flush_o(flush_o), .misaligned_o(misaligned_o),
      .redirect_pending_o(redirect_pending_o),
      .bru_update_i(bru_update_i), .bru_pc_i(bru_pc_i),
      .bru_taken_i(bru_taken_i), .bru_target_i(bru_target_i),
      .pred_taken_o(pred_taken_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        en, rdy, mret, irq, jump, branch;
      logic [31:0] mepc, vec, tgt;
      logic [31:0] e_pc;
      logic        e_valid, e_flush, e_mis, e_pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic en, logic rdy, logic mret, logic irq, logic jump,
                               logic branch, logic [31:0] mepc, logic [31:0] vec,
                               logic [31:0] tgt, logic [31:0] e_pc, logic e_valid,
                               logic e_flush, logic e_mis, logic e_pend);
      vec_t v;
      v.en = en; v.rdy = rdy; v.mret = mret; v.irq = irq; v.jump = jump; v.branch = branch;
      v.mepc = mepc; v.vec = vec; v.tgt = tgt; v.e_pc = e_pc; v.e_valid = e_valid;
      v.e_flush = e_flush; v.e_mis = e_mis; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_redir();
      mret_i = 1'b0; irq_prep_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ni = 1'b0; enable_design_i = 1'b0; initial_pc_i = 32'h8000_0000;
      fetch_ready_i = 1'b0; clr_redir();
      target_pc_i = '0; irq_vector_i = '0; mepc_i = '0;
      bru_update_i = 1'b0; bru_pc_i = '0; bru_taken_i = 1'b0; bru_target_i = '0;

      // en rdy mret irq jmp br  mepc vec tgt | pc valid flush mis pend
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h0,        0,0,0,0)); // IDLE->LOAD
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h8000_0000,1,0,0,0)); // LOAD->RUN
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h8000_0004,1,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h8000_0008,1,0,0,0));
      tbl.push_back(mk(1,1,1,1,0,1, 32'h100,32'h200,32'h300, 32'h100,1,1,0,0)); // priority
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h104,      1,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,1, 0,0,32'h1002,       32'h1000,     1,1,1,0)); // misaligned
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,              32'h1000,     1,0,0,0));
      tbl.push_back(mk(1,0,0,0,1,0, 0,0,32'hFFFF_FFFC,  32'hFFFF_FFFC,1,1,0,0)); // redirect w/o ready
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,              32'hFFFF_FFFC,1,0,0,0)); // stall x3
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,              32'hFFFF_FFFC,1,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,              32'hFFFF_FFFC,1,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h0,        1,0,0,0)); // wrap
      tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,              32'h4,        0,0,0,0)); // RUN->HALT
      tbl.push_back(mk(0,1,0,0,1,0, 0,0,32'h400,        32'h4,        0,0,0,1)); // held jump
      tbl.push_back(mk(0,1,0,1,0,0, 0,32'h500,0,        32'h4,        0,0,0,1)); // overwrite
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h500,      1,1,0,0)); // apply pending
      tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,              32'h504,      1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,              32'h508,      0,0,0,0)); // halt again
      tbl.push_back(mk(0,1,0,0,0,1, 0,0,32'h600,        32'h508,      0,0,0,1));
      tbl.push_back(mk(1,1,0,0,1,0, 0,0,32'h700,        32'h700,      1,1,0,0)); // new beats held
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,              32'h700,      1,0,0,0));

      #12;
      chk("reset_pc",    pc_o, 32'h0);
      chk("reset_valid", 32'(pc_valid_o), 32'h0);
      chk("reset_flush", 32'(flush_o), 32'h0);
      chk("reset_mis",   32'(misaligned_o), 32'h0);
      chk("reset_pend",  32'(redirect_pending_o), 32'h0);
      reset_ni = 1'b1;
      #1;
      @(negedge clk_i);

      for (int i = 0; i < tbl.size(); i++) begin
         enable_design_i = tbl[i].en;  fetch_ready_i = tbl[i].rdy;
         mret_i = tbl[i].mret;         irq_prep_i = tbl[i].irq;
         jump_i = tbl[i].jump;         branch_i = tbl[i].branch;
         mepc_i = tbl[i].mepc;         irq_vector_i = tbl[i].vec;
         target_pc_i = tbl[i].tgt;
         step();
         clr_redir();
         #1;
         chk($sformatf("v%0d_pc", i),     pc_o, tbl[i].e_pc);
         chk($sformatf("v%0d_valid", i),  32'(pc_valid_o), 32'(tbl[i].e_valid));
         chk($sformatf("v%0d_flush", i),  32'(flush_o), 32'(tbl[i].e_flush));
         chk($sformatf("v%0d_mis", i),    32'(misaligned_o), 32'(tbl[i].e_mis));
         chk($sformatf("v%0d_pend", i),   32'(redirect_pending_o), 32'(tbl[i].e_pend));
         chk($sformatf("v%0d_nextpc", i), nextpc_o, tbl[i].e_pc + 32'd4);
      end

      // Mid-operation reset clears a held redirect immediately
      enable_design_i = 1'b0; fetch_ready_i = 1'b0;
      step();
      jump_i = 1'b1; target_pc_i = 32'h900;
      step();
      clr_redir();
      chk("halt_pend", 32'(redirect_pending_o), 32'h1);
      #2 reset_ni = 1'b0;
      #1;
      chk("async_rst_pc",    pc_o, 32'h0);
      chk("async_rst_pend",  32'(redirect_pending_o), 32'h0);
      chk("async_rst_valid", 32'(pc_valid_o), 32'h0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      enable_design_i = 1'b1; fetch_ready_i = 1'b0;
      step();
      step();
      chk("reboot_pc",    pc_o, 32'h8000_0000);
      chk("reboot_valid", 32'(pc_valid_o), 32'h1);
      chk("reboot_pend",  32'(redirect_pending_o), 32'h0);
      chk("reboot_flush", 32'(flush_o), 32'h0);

`ifdef PC_BTB_EN
      // Train a taken entry, then walk into it
      bru_update_i = 1'b1; bru_pc_i = 32'h8000_0010; bru_taken_i = 1'b1;
      bru_target_i = 32'h8000_0040;
      step();
      bru_update_i = 1'b0;
      fetch_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("btb_pc",     pc_o, 32'h8000_0010);
      chk("btb_next",   nextpc_o, 32'h8000_0040);
      chk("btb_pred",   32'(pred_taken_o), 32'h1);
      step();
      chk("btb_follow", pc_o, 32'h8000_0040);
      chk("btb_noflush", 32'(flush_o), 32'h0);
      // Not-taken update on the same PC evicts it
      fetch_ready_i = 1'b0;
      bru_update_i = 1'b1; bru_taken_i = 1'b0;
      step();
      bru_update_i = 1'b0;
      jump_i = 1'b1; target_pc_i = 32'h8000_0010;
      step();
      clr_redir();
      #1;
      chk("btb_revisit_pc", pc_o, 32'h8000_0010);
      chk("btb_evict_next", nextpc_o, 32'h8000_0014);
      chk("btb_evict_pred", 32'(pred_taken_o), 32'h0);
`else
      // Without the BTB, bru updates never steer nextpc_o
      bru_update_i = 1'b1; bru_pc_i = 32'h8000_0000; bru_taken_i = 1'b1;
      bru_target_i = 32'h8000_0040;
      step();
      bru_update_i = 1'b0;
      chk("nobtb_next", nextpc_o, 32'h8000_0004);
      chk("nobtb_pred", 32'(pred_taken_o), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_gen_v2.md
Name: pc_gen_v2

Overview:
Parametrised program-counter generator for the riscv32i fetch front end; successor to the single-width PC unit.
- Produces the fetch PC with a valid/ready handshake toward IF.
- Applies redirects in fixed priority: mret > irq > jump/branch. Redirects raised while the design is disabled are held and applied later.
- Optionally predicts taken control flow with a small direct-mapped BTB.
- Sits between the execute/CSR redirect sources and the IF stage.

Parameters:
XLEN, 32, PC and address width in bits.
INST_BYTES, 4, sequential increment in bytes; legal values are 2 and 4. Sets the alignment mask: 4 clears bits [1:0], 2 clears bit [0].
BTB_DEPTH, 8, number of BTB entries; power of two, 2..64. Used only when PC_BTB_EN is defined.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_ni  in  1  asynchronous reset, active-low.
enable_design_i  in  1  global run enable.
initial_pc_i  in  XLEN  boot PC, sampled once in LOAD.
fetch_ready_i  in  1  IF stage accepts pc_o this cycle.
pc_o  out  XLEN  current fetch PC.
pc_valid_o  out  1  pc_o is valid for fetch.
nextpc_o  out  XLEN  PC that will be loaded on the next advance (combinational).
jump_i, branch_i  in  1 each  jump/branch taken, resolved in EX.
target_pc_i  in  XLEN  jump/branch target.
irq_prep_i  in  1  interrupt entry request.
irq_vector_i  in  XLEN  interrupt vector.
mret_i  in  1  return from trap.
mepc_i  in  XLEN  trap return address.
flush_o  out  1  one-cycle pulse: a redirect was applied to PC at this edge.
misaligned_o  out  1  one-cycle pulse: the applied redirect target had nonzero alignment bits.
redirect_pending_o  out  1  a held redirect is waiting for enable.
bru_update_i  in  1  BTB update strobe.
bru_pc_i  in  XLEN  PC of the resolved branch.
bru_taken_i  in  1  resolved outcome.
bru_target_i  in  XLEN  resolved target.
pred_taken_o  out  1  nextpc_o comes from a BTB hit.

Behaviour:
- Reset (async, reset_ni=0) forces: state=IDLE, pc_o=0, pc_valid_o=0, flush_o=0, misaligned_o=0, pending cleared, BTB valid bits cleared.
- State machine (rising edge):
  - IDLE -> LOAD when enable_design_i=1.
  - LOAD (one cycle): PC <= initial_pc_i aligned; redirects arriving in LOAD are dropped; -> RUN.
  - RUN: pc_valid_o=1. If enable_design_i=0 -> HALT.
  - HALT: pc_valid_o=0, PC held. -> RUN when enable_design_i=1.
- Redirect select, same cycle: mret_i -> mepc_i; else irq_prep_i -> irq_vector_i; else (jump_i|branch_i) -> target_pc_i. Lower-priority redirects in the same cycle are discarded.
- RUN with a redirect: PC <= aligned target at the next edge regardless of fetch_ready_i; flush_o=1 for that cycle.
- RUN, no redirect, fetch_ready_i=1: PC <= nextpc_o. With fetch_ready_i=0, PC is held.
- Sequential next PC = PC + INST_BYTES modulo 2^XLEN. 0xFFFFFFFC+4 wraps to 0x00000000; no flag is raised.
- Alignment: targets are masked to INST_BYTES alignment. misaligned_o pulses together with flush_o when any dropped bit was 1.
- HALT or IDLE with a redirect: the target is captured in the pending register and redirect_pending_o=1. A later redirect overwrites it under the same priority rule.
- On HALT->RUN with a pending redirect: PC <= pending target at the transition edge, flush_o pulses, pending is cleared.
- A redirect on the same edge as HALT->RUN takes precedence over the pending one.
- reset_ni asserted mid-operation aborts everything, including the pending redirect, immediately.

Optional Feature:
Macro PC_BTB_EN.
- Defined:
  - BTB organisation: BTB_DEPTH entries of {valid, tag, target}. Index = pc[log2(BTB_DEPTH)+1:2]; tag = the remaining upper bits.
  - Lookup: in RUN with no redirect, a hit on pc_o makes nextpc_o = stored target and pred_taken_o=1.
  - Update on bru_update_i at the edge: taken writes {1, tag, bru_target_i}; not-taken clears valid only when the tag matches.
  - A same-cycle update and lookup returns the old entry (no bypass).
- Undefined: no BTB storage; pred_taken_o=0; bru_* inputs are ignored; nextpc_o = PC+INST_BYTES.

Test Plan:
- Boot: reset_ni=0 then 1, enable=1, initial_pc_i=0x80000000, fetch_ready_i=1 -> LOAD then pc_o=0x80000000, 0x80000004, 0x80000008 on consecutive cycles; pc_valid_o=1 from the RUN state on.
- Priority: in one cycle mret_i=1 (mepc 0x100), irq_prep_i=1 (vector 0x200), branch_i=1 (target 0x300) -> pc_o=0x100 next cycle, flush_o one pulse.
- Stall and wrap: PC=0xFFFFFFFC with fetch_ready_i=0 for 3 cycles -> PC held. Then ready=1 -> pc_o=0x00000000, no flush.
- Disabled redirect: enable=0, jump_i=1 with target 0x400, then irq_prep_i=1 with vector 0x500, then enable=1 -> redirect_pending_o=1 while disabled; pc_o=0x500 after re-enable with one flush_o pulse.
- Misaligned target: branch target 0x1002 with INST_BYTES=4 -> pc_o=0x1000, misaligned_o=1 for one cycle.
- PC_BTB_EN defined: bru update pc 0x80000010 taken to 0x80000040, then fetch reaches 0x80000010 -> nextpc_o=0x80000040, pred_taken_o=1. After a not-taken update on 0x80000010 -> the next visit goes to 0x80000014.
